hex_to_word: RTL and testbench

HEX_TO_WORD -- requirements
Module: hex_to_word

---
 rtl/hex_to_word.sv | 156 +++++++++++++++
 tb/tb_hex_to_word.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_to_word.sv
// hex_to_word: streams "0x" followed by the hex digits of a latched value,
// one ASCII character at a time, over a valid/ready handshake.
// Leading zero digits are optionally suppressed.
module hex_to_word #(
    parameter  int DATA          = 32,
    parameter  int LEADING_ZEROS = 0,
    localparam int NIB           = DATA / 4,
    localparam int LEN_BITS      = $clog2(NIB + 2) + 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic [DATA-1:0]     i_data,
    input  logic                i_ready,
    output logic [7:0]          o_char,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [LEN_BITS-1:0] o_len
);

    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA-1:0]     data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_BITS-1:0] len_q, len_d;

    logic [NIB-1:0]      nz;
    logic [IDX_W-1:0]    start_idx;
    logic [3:0]          nibble;
    logic                xfer;

    // Per-nibble nonzero flags of the incoming value.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nz
            assign nz[gi] = |i_data[gi*4 +: 4];
        end
    endgenerate

    // First digit to print: the top nibble, or the highest nonzero one
    // (nibble 0 when the whole value is zero, so one "0" digit appears).
    always_comb begin
        start_idx = '0;
        if (LEADING_ZEROS != 0) begin
            start_idx = IDX_W'(NIB - 1);
        end else begin
            for (int i = 0; i < NIB; i++) begin
                if (nz[i]) begin
                    start_idx = IDX_W'(i);
                end
            end
        end
    end

    // Character currently pointed at by the nibble index.
    assign nibble = data_q[{idx_q, 2'b00} +: 4];

    // Output decode purely from registered state so a stalled character
    // stays put while i_ready is low.
    always_comb begin
        o_char  = 8'h00;
        o_valid = 1'b0;
        o_busy  = (state_q != S_IDLE);
        o_done  = (state_q == S_DONE);
        case (state_q)
            S_PFX0: begin
                o_char  = 8'h30;
                o_valid = 1'b1;
            end
            S_PFX1: begin
                o_char  = 8'h78;
                o_valid = 1'b1;
            end
            S_DIGIT: begin
                o_char  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                           : (8'h37 + {4'h0, nibble});
                o_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign xfer  = o_valid & i_ready;
    assign o_len = len_q;

    // Next-state logic: start latch, prefix, digit walk, done pulse.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (i_en) begin
                    data_d  = i_data;
                    len_d   = '0;
                    idx_d   = start_idx;
                    state_d = S_PFX0;
                end
            end
            S_PFX0: begin
                if (xfer) begin
                    len_d   = len_q + 1'b1;
                    state_d = S_PFX1;
                end
            end
            S_PFX1: begin
                if (xfer) begin
                    len_d   = len_q + 1'b1;
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (xfer) begin
                    len_d = len_q + 1'b1;
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_hex_to_word.sv
// Directed bench for hex_to_word: one DUT with leading-zero suppression,
// one printing all digits, sharing clock, reset, data and ready.
module tb_hex_to_word;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ready;
    logic        sel;
    logic [31:0] data;

    logic        en0, en1;
    logic [7:0]  c0, c1;
    logic        v0, v1, b0, b1, d0, d1;
    logic [4:0]  l0, l1;

    logic [7:0]  cur_c;
    logic        cur_v, cur_b, cur_d;
    logic [4:0]  cur_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign en0   = en & ~sel;
    assign en1   = en & sel;
    assign cur_c = sel ? c1 : c0;
    assign cur_v = sel ? v1 : v0;
    assign cur_b = sel ? b1 : b0;
    assign cur_d = sel ? d1 : d0;
    assign cur_l = sel ? l1 : l0;

    hex_to_word #(.DATA(32), .LEADING_ZEROS(0)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_en    (en0),
        .i_data  (data),
        .i_ready (ready),
        .o_char  (c0),
        .o_valid (v0),
        .o_busy  (b0),
        .o_done  (d0),
        .o_len   (l0)
    );

    hex_to_word #(.DATA(32), .LEADING_ZEROS(1)) dut_lz (
        .i_clk   (clk),
        .i_reset (rst),
        .i_en    (en1),
        .i_data  (data),
        .i_ready (ready),
        .o_char  (c1),
        .o_valid (v1),
        .o_busy  (b1),
        .o_done  (d1),
        .o_len   (l1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One conversion: start, collect characters, check done/len/idle.
    // en_mask bit k re-asserts i_en (with data 0x99) in cycle k after start.
    task automatic do_conv(input bit lz, input logic [31:0] d, input string exp,
                           input bit toggle, input logic [15:0] en_mask);
        string      got_s;
        int         n;
        int         cyc;
        bit         done_seen;
        bit         hold;
        logic [7:0] held_c;
        got_s     = "";
        n         = 0;
        done_seen = 1'b0;
        hold      = 1'b0;
        held_c    = 8'h00;
        sel       = lz;
        @(negedge clk);
        en    = 1'b1;
        data  = d;
        ready = 1'b1;
        @(posedge clk);
        #1;
        for (cyc = 1; cyc < 60; cyc++) begin
            en    = (cyc < 16) ? en_mask[cyc] : 1'b0;
            data  = en ? 32'h99 : $urandom;
            ready = toggle ? cyc[0] : 1'b1;
            if (cyc == 1) check("busy_start", {31'b0, cur_b}, 32'd1);
            if (hold) begin
                check("hold_char", {24'b0, cur_c}, {24'b0, held_c});
                check("hold_valid", {31'b0, cur_v}, 32'd1);
            end
            hold = 1'b0;
            if (cur_d) begin
                done_seen = 1'b1;
                break;
            end
            if (cur_v && ready) begin
                if (n < exp.len())
                    check($sformatf("char%0d", n), {24'b0, cur_c}, {24'b0, exp[n]});
                else
                    check("extra_char", n + 1, exp.len());
                got_s = $sformatf("%s%c", got_s, cur_c);
                n++;
            end else if (cur_v && !ready) begin
                hold   = 1'b1;
                held_c = cur_c;
            end
            @(posedge clk);
            #1;
        end
        check("done_seen", {31'b0, done_seen}, 32'd1);
        check("char_count", n, exp.len());
        check("len_done", {27'b0, cur_l}, exp.len());
        check("valid_in_done", {31'b0, cur_v}, 32'd0);
        if (!toggle) check("cycles", cyc, exp.len() + 1);
        @(posedge clk);
        #1;
        en = 1'b0;
        check("done_pulse", {31'b0, cur_d}, 32'd0);
        check("busy_after", {31'b0, cur_b}, 32'd0);
        check("len_hold", {27'b0, cur_l}, exp.len());
        $display("conv lz=%0d data=%08h out=\"%s\" len=%0d", lz, d, got_s, cur_l);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        ready = 1'b0;
        sel   = 1'b0;
        data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_char", {24'b0, c0}, 32'd0);
        check("rst_valid", {31'b0, v0}, 32'd0);
        check("rst_busy", {31'b0, b0}, 32'd0);
        check("rst_done", {31'b0, d0}, 32'd0);
        check("rst_len", {27'b0, l0}, 32'd0);
        check("rst_len_lz", {27'b0, l1}, 32'd0);
        $display("reset char=%0h valid=%0b busy=%0b len=%0d", c0, v0, b0, l0);
        rst = 1'b0;

        do_conv(1'b0, 32'h00001A2F, "0x1A2F", 1'b0, 16'h0000);
        do_conv(1'b0, 32'h00000000, "0x0", 1'b0, 16'h0000);
        do_conv(1'b0, 32'hFFFFFFFF, "0xFFFFFFFF", 1'b1, 16'h0000);
        do_conv(1'b1, 32'h00000005, "0x00000005", 1'b0, 16'h0000);
        do_conv(1'b1, 32'h00001A2F, "0x00001A2F", 1'b1, 16'h0000);
        do_conv(1'b0, 32'h80000000, "0x80000000", 1'b0, 16'h0000);
        do_conv(1'b0, 32'h00000010, "0x10", 1'b0, 16'h0000);
        do_conv(1'b0, 32'h00000012, "0x12", 1'b0, 16'h0024);

        // Abort mid-conversion after three transfers, then restart at once.
        sel = 1'b0;
        @(negedge clk);
        en    = 1'b1;
        data  = 32'h00000ABC;
        ready = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
        data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("mid_len", {27'b0, l0}, 32'd3);
        check("mid_char", {24'b0, c0}, 32'h42);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", {31'b0, v0}, 32'd0);
        check("abort_len", {27'b0, l0}, 32'd0);
        check("abort_busy", {31'b0, b0}, 32'd0);
        check("abort_char", {24'b0, c0}, 32'd0);
        $display("abort valid=%0b len=%0d busy=%0b", v0, l0, b0);
        rst = 1'b0;
        do_conv(1'b0, 32'h00000007, "0x7", 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
